// File: rtl/run_if.sv
// run_if: host/core-facing signal bundle of the run sequencer.
//   req        host -> seq   start request (level, 4-phase)
//   prog_ctr   core -> seq   current program counter
//   core_reset seq  -> core  1 = core PC held in reset
//   mem_sel    seq  -> mux   data memory owner, 1 = host, 0 = core
//   busy       seq  -> host  run in progress (RESET or RUN)
//   done       seq  -> host  run ended at the halt address
//   timeout    seq  -> host  run aborted by the watchdog
//   cycles     seq  -> host  RUN cycles of the current/last run
interface run_if #(
    parameter int D  = 12,
    parameter int CW = 16
) ();
    logic          req;
    logic [D-1:0]  prog_ctr;
    logic          core_reset;
    logic          mem_sel;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycles;

    modport master (
        output req, prog_ctr,
        input  core_reset, mem_sel, busy, done, timeout, cycles
    );

    modport slave (
        input  req, prog_ctr,
        output core_reset, mem_sel, busy, done, timeout, cycles
    );
endinterface

// File: rtl/run_sequencer.sv
// run_sequencer: sequences a core run IDLE -> RESET -> RUN -> DONE/FAULT.
//   clk    system clock, all state on the rising edge
//   reset  synchronous active-high reset, forces IDLE
//   bus    run_if slave: req/prog_ctr in; core_reset, mem_sel, busy,
//          done, timeout, cycles out (all registered)
module run_sequencer #(
    parameter int D         = 12,
    parameter int HALT_ADDR = 128,
    parameter int RST_CYC   = 2,
    parameter int CW        = 16,
    parameter int TIMEOUT   = 4095
) (
    input logic  clk,
    input logic  reset,
    run_if.slave bus
);
    localparam int RW = $clog2(RST_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE,
        S_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic          core_reset_q, mem_sel_q, busy_q, done_q, timeout_q;

    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        cycles_d = cycles_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    state_d  = S_RESET;
                    rcnt_d   = '0;
                    cycles_d = '0;
                end
            end
            S_RESET: begin
                rcnt_d = rcnt_q + 1'b1;
                if (rcnt_q == RW'(RST_CYC - 1)) state_d = S_RUN;
            end
            S_RUN: begin
                // The exiting edge counts too; halt outranks the watchdog.
                cycles_d = cycles_q + 1'b1;
                if (bus.prog_ctr == D'(HALT_ADDR)) state_d = S_DONE;
                else if (cycles_d == CW'(TIMEOUT)) state_d = S_FAULT;
            end
            S_DONE, S_FAULT: begin
                if (!bus.req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step
    // with state_q and stay purely Moore.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rcnt_q       <= '0;
            cycles_q     <= '0;
            core_reset_q <= 1'b1;
            mem_sel_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rcnt_q       <= rcnt_d;
            cycles_q     <= cycles_d;
            core_reset_q <= state_d != S_RUN;
            mem_sel_q    <= state_d inside {S_IDLE, S_DONE, S_FAULT};
            busy_q       <= state_d inside {S_RESET, S_RUN};
            done_q       <= state_d == S_DONE;
            timeout_q    <= state_d == S_FAULT;
        end
    end

    assign bus.core_reset = core_reset_q;
    assign bus.mem_sel    = mem_sel_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.cycles     = cycles_q;
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: randomized scoreboard bench for run_sequencer.
module tb_run_sequencer;
    localparam int HALT = 128;
    localparam int RSTC = 2;
    localparam int TO   = 129;
    localparam int CW   = 16;

    typedef struct {
        bit d;
        bit t;
        int n;
        int at;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] idle_pc;
    logic [11:0] pcs [1:200];
    int          k;
    int          cyc = 0;
    int          ntests = 0;
    int          nfail = 0;
    exp_t        sb[$];

    run_if #(.D(12), .CW(CW)) bus ();

    run_sequencer #(
        .D(12), .HALT_ADDR(HALT), .RST_CYC(RSTC), .CW(CW), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Core model: PC sequence restarts whenever the core is held in reset.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        k   <= bus.core_reset ? 1 : k + 1;
    end

    assign bus.prog_ctr = bus.core_reset ? idle_pc : ((k >= 1 && k <= 200) ? pcs[k] : 12'd0);

    function automatic void chk(string nm, int act, int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitor: every rising edge of a terminal flag pops one expected run.
    initial begin
        bit   prev;
        bit   term;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            term = (bus.done === 1'b1) || (bus.timeout === 1'b1);
            if (term && !prev) begin
                if (sb.size() == 0) chk("unexpected_term", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("term_done", int'(bus.done), int'(e.d));
                    chk("term_timeout", int'(bus.timeout), int'(e.t));
                    chk("term_cycles", int'(bus.cycles), e.n);
                    chk("term_time", cyc, e.at);
                    chk("term_core_reset", int'(bus.core_reset), 1);
                    chk("term_mem_sel", int'(bus.mem_sel), 1);
                    chk("term_busy", int'(bus.busy), 0);
                end
            end
            prev = term;
        end
    end

    // Fill the PC trace for a run and derive the outcome from the rules:
    // first RUN cycle showing HALT ends it, else the watchdog at TO.
    task automatic build(input int mode, input int v, output exp_t e);
        int kh;
        for (int i = 1; i <= 200; i++) begin
            case (mode)
                0: pcs[i] = 12'(i - 1);
                1: pcs[i] = 12'(v);
                2: begin
                    pcs[i] = 12'($urandom_range(0, 4095));
                    if (pcs[i] == 12'(HALT)) pcs[i] = 12'(HALT - 1);
                    if (i == v) pcs[i] = 12'(HALT);
                end
                default: pcs[i] = 12'(v + i - 1);
            endcase
        end
        kh = 0;
        for (int i = 1; i <= TO; i++)
            if (kh == 0 && pcs[i] == 12'(HALT)) kh = i;
        e.d = kh != 0;
        e.t = kh == 0;
        e.n = (kh != 0) ? kh : TO;
    endtask

    task automatic start_req(input bit tog, output int c);
        @(negedge clk);
        c = cyc;
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = tog ? 1'($urandom) : 1'b0;
        chk("start_busy", int'(bus.busy), 1);
        chk("start_core_reset", int'(bus.core_reset), 1);
        chk("start_mem_sel", int'(bus.mem_sel), 0);
        chk("start_cycles", int'(bus.cycles), 0);
        repeat (RSTC - 1) begin
            @(negedge clk);
            if (tog) bus.req = 1'($urandom);
        end
        chk("reset_core_held", int'(bus.core_reset), 1);
        @(negedge clk);
        chk("run_core_free", int'(bus.core_reset), 0);
    endtask

    task automatic do_run(input int mode, input int v, input int hold, input bit tog);
        exp_t e;
        int   c;
        int   n;
        build(mode, v, e);
        @(negedge clk);
        e.at = cyc + 1 + 1 + RSTC + e.n;
        sb.push_back(e);
        start_req(tog, c);
        n = 0;
        while (!(bus.done === 1'b1 || bus.timeout === 1'b1) && n < TO + 10) begin
            if (tog) bus.req = 1'($urandom);
            @(negedge clk);
            n++;
        end
        if (n >= TO + 10) begin
            chk("run_never_ended", 0, 1);
            bus.req = 1'b0;
            return;
        end
        bus.req = hold > 0;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk("hold_done", int'(bus.done), int'(e.d));
            chk("hold_timeout", int'(bus.timeout), int'(e.t));
            chk("hold_cycles", int'(bus.cycles), e.n);
            bus.req = 1'b0;
        end
        @(negedge clk);
        chk("idle_done", int'(bus.done), 0);
        chk("idle_timeout", int'(bus.timeout), 0);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_core_reset", int'(bus.core_reset), 1);
        chk("idle_mem_sel", int'(bus.mem_sel), 1);
    endtask

    task automatic mid_reset(input int r);
        exp_t e;
        int   c;
        build(1, 5, e);
        start_req(1'b0, c);
        repeat (r - 1) @(negedge clk);
        chk("pre_reset_cycles", int'(bus.cycles), r - 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_core_reset", int'(bus.core_reset), 1);
        chk("mrst_mem_sel", int'(bus.mem_sel), 1);
        chk("mrst_busy", int'(bus.busy), 0);
        chk("mrst_cycles", int'(bus.cycles), 0);
        chk("mrst_done", int'(bus.done), 0);
    endtask

    initial begin
        reset   = 1'b1;
        bus.req = 1'b0;
        idle_pc = 12'd0;
        repeat (3) @(negedge clk);
        chk("rst_core_reset", int'(bus.core_reset), 1);
        chk("rst_mem_sel", int'(bus.mem_sel), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_timeout", int'(bus.timeout), 0);
        chk("rst_cycles", int'(bus.cycles), 0);
        reset = 1'b0;
        do_run(0, 0, 0, 1'b0);
        do_run(1, 5, 0, 1'b0);
        do_run(0, 0, 10, 1'b0);
        do_run(3, 60, 0, 1'b0);
        mid_reset(50);
        do_run(2, 40, 2, 1'b1);
        idle_pc = 12'(HALT);
        repeat (5) @(negedge clk);
        do_run(1, HALT, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            int m;
            int v;
            m = $urandom_range(0, 3);
            v = (m == 1) ? $urandom_range(0, 4095) : (m == 2) ? $urandom_range(1, 160) : $urandom_range(0, 140);
            idle_pc = 12'($urandom_range(0, 4095));
            do_run(m, v, $urandom_range(0, 5), 1'($urandom));
        end
        idle_pc = 12'd0;
        mid_reset($urandom_range(1, 120));
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
Run controller for the single-cycle core. It owns the core's reset line and the data-memory ownership select, and accepts a start request from the host. It sequences each run IDLE -> RESET -> RUN -> DONE/FAULT and detects the halt address on the program counter. It counts execution cycles and enforces a watchdog timeout. It sits between the host/testbench request interface and the core (PC, reg_file, dat_mem mux).

Parameters:
D, 12, program counter width (matches PC)
HALT_ADDR, 128, prog_ctr value that marks program completion
RST_CYC, 2, cycles core_reset is held after a start request (>=1)
CW, 16, cycle counter width
TIMEOUT, 4095, maximum RUN cycles before fault; must satisfy 1 <= TIMEOUT < 2^CW

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; forces IDLE
req  input  1  host start request (level, 4-phase handshake)
prog_ctr  input  D  current program counter from core
core_reset  output  1  drives core PC reset; 1 = core held
mem_sel  output  1  data memory owner; 1 = host, 0 = core
busy  output  1  1 in RESET or RUN
done  output  1  run completed at HALT_ADDR
timeout  output  1  run aborted by watchdog
cycles  output  CW  cycles spent in RUN for the current/last run

Behaviour:
- One clock; reset is synchronous and active-high. reset=1 at a clock edge wins over everything, including mid-run.
- Reset values: state=IDLE, core_reset=1, mem_sel=1, busy=0, done=0, timeout=0, cycles=0, internal reset counter=0.
- Moore outputs, decoded from registered state only. cycles is a register.
  - IDLE: core_reset=1, mem_sel=1.
  - RESET: core_reset=1, mem_sel=0, busy=1.
  - RUN: core_reset=0, mem_sel=0, busy=1.
  - DONE: core_reset=1, mem_sel=1, done=1.
  - FAULT: core_reset=1, mem_sel=1, timeout=1.
- IDLE: req=1 sampled -> RESET next cycle. On that edge, cycles<=0 and the reset counter<=0. A one-cycle req pulse is sufficient.
- RESET: the reset counter increments each edge. After exactly RST_CYC cycles in RESET -> RUN.
- RUN:
  - cycles<=cycles+1 on every edge in RUN, including the exiting edge.
  - If prog_ctr==HALT_ADDR -> DONE.
  - Else if cycles+1==TIMEOUT -> FAULT.
  - Halt has priority when both conditions hold on the same edge.
  - req changes during RESET/RUN are ignored.
- DONE/FAULT: cycles holds its value. Stay while req=1. req=0 -> IDLE next cycle; the flag clears in IDLE.
- A new req after returning to IDLE starts a fresh run, with cycles cleared on entry to RESET.
- cycles never wraps: TIMEOUT < 2^CW guarantees exit first.
- prog_ctr is ignored outside RUN. A stale HALT_ADDR value during RESET must not trigger DONE.
- Latency:
  - req sampled high -> busy=1 after 1 cycle.
  - core_reset falls RST_CYC+1 cycles after the req edge.
  - Halt seen in RUN -> done=1 the following cycle.

Test Plan:
- Nominal run: power-on reset, req=1 for 1 cycle, core model counts prog_ctr from 0 while core_reset=0. Required response:
  - busy=1 one cycle after req.
  - core_reset low after 3 cycles.
  - DONE when prog_ctr=128, with cycles=129, done=1, mem_sel=1, core_reset=1.
- Watchdog: TIMEOUT=100, prog_ctr held at 5. Required: FAULT after the 100th RUN cycle, timeout=1, done=0, cycles=100.
- Simultaneous: TIMEOUT=129 with the nominal core model. Required: halt and timeout coincide at cycle 129 -> DONE, timeout=0, cycles=129.
- Handshake: hold req=1 through DONE for 10 cycles. Required: stays DONE with done=1. Drop req -> IDLE next cycle, done=0. Re-raise req -> RESET, cycles=0.
- Mid-run reset: assert reset at RUN cycle 50. Required next cycle: IDLE, core_reset=1, mem_sel=1, busy=0, cycles=0. req toggling during RUN in a separate run has no effect.
- Stale PC: prog_ctr=128 forced during IDLE and RESET. Required: no DONE until a RUN-state match; the first RUN cycle with prog_ctr=128 -> DONE, cycles=1.
